// File: rtl/mult_arb_pkg.sv
// Shared constants for the two-requester sequential multiplier: FSM encoding,
// requester ids and the round-robin pick helper.
package mult_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic ID0 = 1'b0;
  localparam logic ID1 = 1'b1;

  // A lone request wins outright; a tie is resolved by the priority pointer.
  function automatic logic arb_pick(input logic i_req0, input logic i_req1, input logic i_ptr);
    logic v_pick;
    if (i_req0 && i_req1) begin
      v_pick = i_ptr;
    end else if (i_req1) begin
      v_pick = ID1;
    end else begin
      v_pick = ID0;
    end
    return v_pick;
  endfunction

endpackage

// File: rtl/mult_seq.sv
// Shift-add datapath: operand registers, accumulator and iteration counter.
// Optional MULT_ARB_ZERO_SKIP_EN finishes a zero-operand pair on its first step.
module mult_seq #(
  parameter int w = 4
) (
  input  logic           clk,
  input  logic           rst_b,
  input  logic           i_start,
  input  logic           i_step,
  input  logic [w-1:0]   i_a,
  input  logic [w-1:0]   i_b,
  output logic           o_last,
  output logic [2*w-1:0] o_prod
);

  localparam int CW = $clog2(w + 1);

  logic [2*w-1:0] r_a;
  logic [w-1:0]   r_b;
  logic [2*w-1:0] r_acc;
  logic [CW-1:0]  r_cnt;
  logic [2*w-1:0] w_addend;
  logic [2*w-1:0] w_acc_nxt;

  assign w_addend  = r_b[0] ? r_a : {(2*w){1'b0}};
  assign w_acc_nxt = r_acc + w_addend;
  // o_prod is the accumulator after the current step, i.e. the product on the last step.
  assign o_prod    = w_acc_nxt;

`ifdef MULT_ARB_ZERO_SKIP_EN
  assign o_last = (r_cnt == CW'(w - 1)) ||
                  ((r_cnt == {CW{1'b0}}) && ((r_a == {(2*w){1'b0}}) || (r_b == {w{1'b0}})));
`else
  assign o_last = (r_cnt == CW'(w - 1));
`endif

  // Load operands on start, then one shift-add iteration per step.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_a   <= {(2*w){1'b0}};
      r_b   <= {w{1'b0}};
      r_acc <= {(2*w){1'b0}};
      r_cnt <= {CW{1'b0}};
    end else if (i_start) begin
      r_a   <= {{w{1'b0}}, i_a};
      r_b   <= i_b;
      r_acc <= {(2*w){1'b0}};
      r_cnt <= {CW{1'b0}};
    end else if (i_step) begin
      r_a   <= {r_a[2*w-2:0], 1'b0};
      r_b   <= {1'b0, r_b[w-1:1]};
      r_acc <= w_acc_nxt;
      r_cnt <= r_cnt + CW'(1);
    end else begin
      r_a   <= r_a;
      r_b   <= r_b;
      r_acc <= r_acc;
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/mult_arb_seq.sv
// Two-requester round-robin front end for a w-cycle shift-add multiplier.
// Honors MULT_ARB_ZERO_SKIP_EN through the mult_seq datapath.
module mult_arb_seq
  import mult_arb_pkg::*;
#(
  parameter int w = 4
) (
  input  logic           clk,
  input  logic           rst_b,
  input  logic           req0,
  input  logic           req1,
  input  logic [w-1:0]   a0,
  input  logic [w-1:0]   b0,
  input  logic [w-1:0]   a1,
  input  logic [w-1:0]   b1,
  output logic           gnt0,
  output logic           gnt1,
  output logic           busy,
  output logic [2*w-1:0] out,
  output logic           out_id,
  output logic           out_vld
);

  state_t         r_state;
  state_t         w_state_nxt;
  logic           r_ptr;
  logic           r_id;
  logic           r_gnt0;
  logic           r_gnt1;
  logic [2*w-1:0] r_out;
  logic           r_out_id;
  logic           r_out_vld;

  logic           w_pick;
  logic           w_start;
  logic           w_step;
  logic           w_last;
  logic           w_done;
  logic           w_gnt0_d;
  logic           w_gnt1_d;
  logic [w-1:0]   w_a;
  logic [w-1:0]   w_b;
  logic [2*w-1:0] w_prod;

  assign w_pick  = arb_pick(req0, req1, r_ptr);
  assign w_start = (r_state == ST_IDLE) && (req0 || req1);
  assign w_step  = (r_state == ST_BUSY);
  assign w_done  = w_step && w_last;
  assign w_a     = (w_pick == ID1) ? a1 : a0;
  assign w_b     = (w_pick == ID1) ? b1 : b0;

  mult_seq #(.w(w)) u_mult_seq (
    .clk     (clk),
    .rst_b   (rst_b),
    .i_start (w_start),
    .i_step  (w_step),
    .i_a     (w_a),
    .i_b     (w_b),
    .o_last  (w_last),
    .o_prod  (w_prod)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req0 || req1) begin
          w_state_nxt = ST_BUSY;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (w_last) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_BUSY;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode ahead of the output registers.
  always_comb begin
    w_gnt0_d = 1'b0;
    w_gnt1_d = 1'b0;
    if (w_start) begin
      w_gnt0_d = (w_pick == ID0);
      w_gnt1_d = (w_pick == ID1);
    end else begin
      w_gnt0_d = 1'b0;
      w_gnt1_d = 1'b0;
    end
  end

  // Grant pulses, pointer/owner tracking and the held result.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_ptr     <= ID0;
      r_id      <= ID0;
      r_out     <= {(2*w){1'b0}};
      r_out_id  <= ID0;
      r_out_vld <= 1'b0;
    end else begin
      r_gnt0    <= w_gnt0_d;
      r_gnt1    <= w_gnt1_d;
      r_out_vld <= w_done;
      if (w_start) begin
        r_ptr <= ~w_pick;
        r_id  <= w_pick;
      end else begin
        r_ptr <= r_ptr;
        r_id  <= r_id;
      end
      if (w_done) begin
        r_out    <= w_prod;
        r_out_id <= r_id;
      end else begin
        r_out    <= r_out;
        r_out_id <= r_out_id;
      end
    end
  end

  assign gnt0    = r_gnt0;
  assign gnt1    = r_gnt1;
  assign busy    = (r_state == ST_BUSY);
  assign out     = r_out;
  assign out_id  = r_out_id;
  assign out_vld = r_out_vld;

endmodule

// File: tb/tb_mult_arb_seq.sv
// Directed bench for mult_arb_seq: vector table plus hand-written arbitration,
// reset-abort and w=6 sequences. Zero-operand latency follows MULT_ARB_ZERO_SKIP_EN.
module tb_mult_arb_seq;

`ifdef MULT_ARB_ZERO_SKIP_EN
  localparam int ZL = 1;
`else
  localparam int ZL = 4;
`endif

  typedef struct {
    logic       id;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] exp;
    int         lat;
  } vec_t;

  logic       clk;
  logic       rst_b;
  logic       req0, req1;
  logic [3:0] a0, b0, a1, b1;
  logic       gnt0, gnt1, busy, out_id, out_vld;
  logic [7:0] out;

  logic        req0_6, req1_6;
  logic [5:0]  a0_6, b0_6, a1_6, b1_6;
  logic        gnt0_6, gnt1_6, busy_6, out_id_6, out_vld_6;
  logic [11:0] out_6;

  int n_tests = 0;
  int n_fail  = 0;

  mult_arb_seq #(.w(4)) dut (
    .clk(clk), .rst_b(rst_b), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy),
    .out(out), .out_id(out_id), .out_vld(out_vld)
  );

  mult_arb_seq #(.w(6)) dut6 (
    .clk(clk), .rst_b(rst_b), .req0(req0_6), .req1(req1_6),
    .a0(a0_6), .b0(b0_6), .a1(a1_6), .b1(b1_6),
    .gnt0(gnt0_6), .gnt1(gnt1_6), .busy(busy_6),
    .out(out_6), .out_id(out_id_6), .out_vld(out_vld_6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  task automatic wait_gnt(input string name, output logic gid);
    logic ok;
    ok = 1'b0;
    gid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin
        ok = 1'b1;
        gid = gnt1;
        break;
      end
    end
    chk({name, " grant_seen"}, {31'd0, ok}, 32'd1);
    chk({name, " gnt_onehot"}, {31'd0, gnt0 & gnt1}, 32'd0);
  endtask

  task automatic wait_vld(input string name, input logic [7:0] exp, input logic exp_id, input int exp_lat);
    logic saw;
    int   lat;
    saw = 1'b0;
    lat = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (out_vld) begin
        lat = i;
        break;
      end
      if (gnt0 || gnt1) saw = 1'b1;
    end
    chk({name, " latency"}, lat, exp_lat);
    chk({name, " out"}, {24'd0, out}, {24'd0, exp});
    chk({name, " out_id"}, {31'd0, out_id}, {31'd0, exp_id});
    chk({name, " no_gnt_busy"}, {31'd0, saw}, 32'd0);
  endtask

  task automatic run_one(input string name, input vec_t v);
    logic gid;
    @(negedge clk);
    req0 = (v.id == 1'b0);
    req1 = (v.id == 1'b1);
    if (v.id) begin a1 = v.a; b1 = v.b; end
    else begin a0 = v.a; b0 = v.b; end
    wait_gnt(name, gid);
    chk({name, " gnt_id"}, {31'd0, gid}, {31'd0, v.id});
    chk({name, " busy"}, {31'd0, busy}, 32'd1);
    req0 = 1'b0; req1 = 1'b0;
    wait_vld(name, v.exp, v.id, v.lat);
    @(negedge clk);
    chk({name, " vld_pulse"}, {31'd0, out_vld}, 32'd0);
    chk({name, " out_hold"}, {24'd0, out}, {24'd0, v.exp});
    chk({name, " idle"}, {31'd0, busy}, 32'd0);
  endtask

  vec_t vecs[7];

  initial begin
    logic gid;
    int   seq[4];
    int   got;
    int   lat6;

    vecs[0] = '{1'b0, 4'd5,  4'd10, 8'd50,  4};
    vecs[1] = '{1'b1, 4'd15, 4'd15, 8'd225, 4};
    vecs[2] = '{1'b0, 4'd0,  4'd9,  8'd0,   ZL};
    vecs[3] = '{1'b1, 4'd7,  4'd0,  8'd0,   ZL};
    vecs[4] = '{1'b0, 4'd1,  4'd1,  8'd1,   4};
    vecs[5] = '{1'b1, 4'd12, 4'd11, 8'd132, 4};
    vecs[6] = '{1'b0, 4'd15, 4'd1,  8'd15,  4};

    req0 = 1'b0; req1 = 1'b0;
    a0 = 4'd0; b0 = 4'd0; a1 = 4'd0; b1 = 4'd0;
    req0_6 = 1'b0; req1_6 = 1'b0;
    a0_6 = 6'd0; b0_6 = 6'd0; a1_6 = 6'd0; b1_6 = 6'd0;

    rst_b = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst out", {24'd0, out}, 32'd0);
    chk("rst out_id", {31'd0, out_id}, 32'd0);
    chk("rst out_vld", {31'd0, out_vld}, 32'd0);
    chk("rst gnt", {30'd0, gnt1, gnt0}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    rst_b = 1'b1;

    for (int i = 0; i < 7; i++) run_one($sformatf("vec%0d", i), vecs[i]);

    // Simultaneous requests: 0 first, 1 served at the edge ending the out_vld cycle.
    do_reset();
    @(negedge clk);
    req0 = 1'b1; req1 = 1'b1;
    a0 = 4'd3; b0 = 4'd4; a1 = 4'd15; b1 = 4'd15;
    wait_gnt("both g0", gid);
    chk("both g0 id", {31'd0, gid}, 32'd0);
    req0 = 1'b0;
    wait_vld("both v0", 8'd12, 1'b0, 4);
    @(negedge clk);
    chk("both g1 gnt1", {31'd0, gnt1}, 32'd1);
    chk("both g1 gnt0", {31'd0, gnt0}, 32'd0);
    req1 = 1'b0;
    wait_vld("both v1", 8'd225, 1'b1, 4);

    // Both held continuously: grants alternate.
    do_reset();
    @(negedge clk);
    req0 = 1'b1; req1 = 1'b1;
    a0 = 4'd2; b0 = 4'd3; a1 = 4'd4; b1 = 4'd5;
    seq = '{9, 9, 9, 9};
    got = 0;
    for (int i = 0; i < 60 && got < 4; i++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin
        chk("rr onehot", {31'd0, gnt0 & gnt1}, 32'd0);
        seq[got] = gnt1 ? 1 : 0;
        got++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("rr grants", got, 4);
    for (int k = 0; k < 4; k++) chk($sformatf("rr seq%0d", k), seq[k], k % 2);
    wait_vld("rr drain", 8'd20, 1'b1, 4);

    // Reset two cycles into BUSY aborts; pointer returns to requester 0.
    do_reset();
    @(negedge clk);
    req0 = 1'b1; req1 = 1'b1;
    a0 = 4'd9; b0 = 4'd9; a1 = 4'd2; b1 = 4'd2;
    wait_gnt("abort g", gid);
    chk("abort g id", {31'd0, gid}, 32'd0);
    req0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    chk("abort out_vld", {31'd0, out_vld}, 32'd0);
    chk("abort out", {24'd0, out}, 32'd0);
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort gnt", {30'd0, gnt1, gnt0}, 32'd0);
    rst_b = 1'b1;
    req0 = 1'b1;
    wait_gnt("abort next", gid);
    chk("abort next id", {31'd0, gid}, 32'd0);
    req0 = 1'b0; req1 = 1'b0;
    wait_vld("abort next v", 8'd81, 1'b0, 4);

    // w=6 instance, requester 1 at full scale.
    @(negedge clk);
    req1_6 = 1'b1; a1_6 = 6'd63; b1_6 = 6'd63;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gnt1_6) begin got = 1; break; end
    end
    chk("w6 gnt1", got, 1);
    req1_6 = 1'b0;
    lat6 = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (out_vld_6) begin lat6 = i; break; end
    end
    chk("w6 latency", lat6, 6);
    chk("w6 out", {20'd0, out_6}, 32'd3969);
    chk("w6 out_id", {31'd0, out_id_6}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
